// File: rtl/multicycle_pc_controller.sv
// Multi-cycle instruction sequencer that drives PC, IR, memory and writeback controls.
// Optional build macro MEM_WAIT_EN: FETCH and MEM stall until input_memReady is high.
module multicycle_pc_controller (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [3:0]  input_opcode,
    input  logic        input_memReady,
    output logic        output_PCWrite,
    output logic        output_PC_isbranch,
    output logic        output_PC_set,
    output logic [1:0]  output_branchType,
    output logic        output_IRWrite,
    output logic        output_MemRead,
    output logic        output_MemWrite,
    output logic        output_RegWrite,
    output logic        output_MemToReg,
    output logic        output_ALUSrcB,
    output logic        output_ALUSub,
    output logic [2:0]  output_state,
    output logic [15:0] output_instrCount
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_JUMP   = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] instr_count;
    logic        mem_ready;
    logic        op_illegal;
    logic        pc_write;
    logic        pc_isbranch;
    logic        pc_set;
    logic [1:0]  branch_type;
    logic        ir_write;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        alu_src_b;
    logic        alu_sub;

`ifdef MEM_WAIT_EN
    assign mem_ready = input_memReady;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = input_memReady;
    assign mem_ready        = 1'b1;
`endif

    // Opcodes 10..15 have no handler and are skipped from DECODE.
    assign op_illegal = input_opcode[3] & (input_opcode[2] | input_opcode[1]);

    always_comb begin
        state_next  = state;
        pc_write    = 1'b0;
        pc_isbranch = 1'b0;
        pc_set      = 1'b0;
        branch_type = 2'b00;
        ir_write    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_b   = 1'b0;
        alu_sub     = 1'b0;

        case (state)
            S_FETCH: begin
                ir_write = 1'b1;
                mem_read = 1'b1;
                if (mem_ready)
                    state_next = S_DECODE;
            end
            S_DECODE: begin
                if (op_illegal) begin
                    pc_write   = 1'b1;
                    state_next = S_FETCH;
                end else if (input_opcode == 4'd9) begin
                    state_next = S_HALT;
                end else if (input_opcode == 4'd8) begin
                    state_next = S_JUMP;
                end else if (input_opcode[2]) begin
                    state_next = S_BRANCH;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src_b  = (input_opcode != 4'd0);
                state_next = (input_opcode[1]) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (input_opcode == 4'd2) begin
                    mem_read = 1'b1;
                    if (mem_ready)
                        state_next = S_WB;
                end else begin
                    // Store retires here; its PC update waits for memory to finish.
                    mem_write = 1'b1;
                    pc_write  = mem_ready;
                    if (mem_ready)
                        state_next = S_FETCH;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (input_opcode == 4'd2);
                pc_write   = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_sub     = 1'b1;
                pc_write    = 1'b1;
                pc_isbranch = 1'b1;
                branch_type = input_opcode[1:0];
                state_next  = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_set     = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        // Reset abandons the instruction in flight, so nothing may strobe this cycle.
        if (Reset) begin
            pc_write    = 1'b0;
            pc_isbranch = 1'b0;
            pc_set      = 1'b0;
            branch_type = 2'b00;
            ir_write    = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            reg_write   = 1'b0;
            mem_to_reg  = 1'b0;
            alu_src_b   = 1'b0;
            alu_sub     = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= S_FETCH;
            instr_count <= 16'd0;
        end else begin
            state <= state_next;
            if (pc_write)
                instr_count <= instr_count + 16'd1;
        end
    end

    assign output_PCWrite     = pc_write;
    assign output_PC_isbranch = pc_isbranch;
    assign output_PC_set      = pc_set;
    assign output_branchType  = branch_type;
    assign output_IRWrite     = ir_write;
    assign output_MemRead     = mem_read;
    assign output_MemWrite    = mem_write;
    assign output_RegWrite    = reg_write;
    assign output_MemToReg    = mem_to_reg;
    assign output_ALUSrcB     = alu_src_b;
    assign output_ALUSub      = alu_sub;
    assign output_state       = state;
    assign output_instrCount  = instr_count;

endmodule

// File: tb/tb_multicycle_pc_controller.sv
// Bench for multicycle_pc_controller: per-opcode phase lists drive a cycle-by-cycle model.
// Build with MEM_WAIT_EN defined to also exercise memory stalls.
module tb_multicycle_pc_controller;

    logic        CLK;
    logic        Reset;
    logic [3:0]  input_opcode;
    logic        input_memReady;
    logic        output_PCWrite;
    logic        output_PC_isbranch;
    logic        output_PC_set;
    logic [1:0]  output_branchType;
    logic        output_IRWrite;
    logic        output_MemRead;
    logic        output_MemWrite;
    logic        output_RegWrite;
    logic        output_MemToReg;
    logic        output_ALUSrcB;
    logic        output_ALUSub;
    logic [2:0]  output_state;
    logic [15:0] output_instrCount;

    multicycle_pc_controller dut (
        .CLK                (CLK),
        .Reset              (Reset),
        .input_opcode       (input_opcode),
        .input_memReady     (input_memReady),
        .output_PCWrite     (output_PCWrite),
        .output_PC_isbranch (output_PC_isbranch),
        .output_PC_set      (output_PC_set),
        .output_branchType  (output_branchType),
        .output_IRWrite     (output_IRWrite),
        .output_MemRead     (output_MemRead),
        .output_MemWrite    (output_MemWrite),
        .output_RegWrite    (output_RegWrite),
        .output_MemToReg    (output_MemToReg),
        .output_ALUSrcB     (output_ALUSrcB),
        .output_ALUSub      (output_ALUSub),
        .output_state       (output_state),
        .output_instrCount  (output_instrCount)
    );

`ifdef MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    localparam logic [2:0] PH_F = 3'd0, PH_D = 3'd1, PH_E = 3'd2, PH_M = 3'd3;
    localparam logic [2:0] PH_W = 3'd4, PH_B = 3'd5, PH_J = 3'd6, PH_H = 3'd7;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] model_count;
    logic [11:0] last_ctrl;
    int          tally_mw;
    int          tally_pcw;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // {PCWrite, isbranch, set, branchType[1:0], IRWrite, MemRead, MemWrite, RegWrite, MemToReg, ALUSrcB, ALUSub}
    function automatic logic [11:0] dut_ctrl();
        return {output_PCWrite, output_PC_isbranch, output_PC_set, output_branchType,
                output_IRWrite, output_MemRead, output_MemWrite, output_RegWrite,
                output_MemToReg, output_ALUSrcB, output_ALUSub};
    endfunction

    function automatic logic [11:0] exp_ctrl(input logic [2:0] p, input logic [3:0] op, input bit rdy);
        logic pcw, br, st, irw, mr, mw, rw, m2r, asb, sub;
        logic [1:0] bt;
        pcw = 0; br = 0; st = 0; bt = 2'b00; irw = 0; mr = 0;
        mw = 0; rw = 0; m2r = 0; asb = 0; sub = 0;
        case (p)
            PH_F: begin irw = 1; mr = 1; end
            PH_D: pcw = (op >= 4'd10);
            PH_E: asb = (op >= 4'd1 && op <= 4'd3);
            PH_M: begin
                mr  = (op == 4'd2);
                mw  = (op == 4'd3);
                pcw = (op == 4'd3) && (rdy || !WAIT_EN);
            end
            PH_W: begin rw = 1; m2r = (op == 4'd2); pcw = 1; end
            PH_B: begin sub = 1; pcw = 1; br = 1; bt = op[1:0]; end
            PH_J: begin pcw = 1; st = 1; end
            default: ;
        endcase
        return {pcw, br, st, bt, irw, mr, mw, rw, m2r, asb, sub};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic reset_dut(input int cycles);
        Reset = 1'b1;
        input_opcode = 4'($urandom_range(0, 15));
        input_memReady = 1'($urandom_range(0, 1));
        repeat (cycles) begin
            @(negedge CLK);
            chk("reset_ctrl", 32'(dut_ctrl()), 32'd0);
            @(posedge CLK); #1;
        end
        chk("reset_state", 32'(output_state), 32'd0);
        chk("reset_count", 32'(output_instrCount), 32'd0);
        Reset = 1'b0;
        model_count = 16'd0;
        #1;
        chk("first_irwrite", 32'(output_IRWrite), 32'd1);
    endtask

    // Runs one instruction; mem_lows<0 means random readiness, abort_idx>=0 resets at that cycle.
    task automatic run_instr(input logic [3:0] op, input int mem_lows, input int halt_cycles,
                             input int abort_idx);
        logic [2:0] ph[$];
        logic [2:0] p;
        logic [11:0] e;
        bit rdy;
        int lows_left;
        int stall;
        int idx;
        lows_left = mem_lows;
        stall = 0;
        idx = 0;
        tally_mw = 0;
        tally_pcw = 0;
        ph.push_back(PH_F);
        ph.push_back(PH_D);
        if (op <= 4'd1) begin ph.push_back(PH_E); ph.push_back(PH_W); end
        else if (op == 4'd2) begin ph.push_back(PH_E); ph.push_back(PH_M); ph.push_back(PH_W); end
        else if (op == 4'd3) begin ph.push_back(PH_E); ph.push_back(PH_M); end
        else if (op <= 4'd7) ph.push_back(PH_B);
        else if (op == 4'd8) ph.push_back(PH_J);
        else if (op == 4'd9) repeat (halt_cycles) ph.push_back(PH_H);
        while (ph.size() > 0) begin
            p = ph[0];
            if (p == PH_M && mem_lows >= 0) begin
                rdy = (lows_left > 0) ? 1'b0 : 1'b1;
                lows_left--;
            end else if (stall >= 3) begin
                rdy = 1'b1;
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
            end
            input_memReady = rdy;
            input_opcode = (p == PH_F) ? 4'($urandom_range(0, 15)) : op;
            if (idx == abort_idx) begin
                Reset = 1'b1;
                @(negedge CLK);
                chk("abort_ctrl", 32'(dut_ctrl()), 32'd0);
                @(posedge CLK); #1;
                Reset = 1'b0;
                model_count = 16'd0;
                chk("abort_state", 32'(output_state), 32'd0);
                chk("abort_count", 32'(output_instrCount), 32'd0);
                return;
            end
            e = exp_ctrl(p, input_opcode, rdy);
            @(negedge CLK);
            chk("state", 32'(output_state), 32'(p));
            chk("ctrl", 32'(dut_ctrl()), 32'(e));
            chk("count", 32'(output_instrCount), 32'(model_count));
            last_ctrl = dut_ctrl();
            tally_mw += int'(output_MemWrite);
            tally_pcw += int'(output_PCWrite);
            @(posedge CLK); #1;
            if (e[11]) model_count = model_count + 16'd1;
            if (WAIT_EN && (p == PH_F || p == PH_M) && !rdy) stall++;
            else begin
                stall = 0;
                void'(ph.pop_front());
            end
            idx++;
        end
    endtask

    initial begin
        Reset = 1'b1;
        input_opcode = 4'd0;
        input_memReady = 1'b0;
        model_count = 16'd0;
        last_ctrl = 12'd0;

        reset_dut(2);
        run_instr(4'd0, -1, 0, -1);
        run_instr(4'd2, -1, 0, -1);
        chk("count_after_r_lw", 32'(output_instrCount), 32'd2);

        run_instr(4'd6, -1, 0, -1);
        chk("bne_ctrl", 32'(last_ctrl), 32'(12'b110_10_0000001));

        reset_dut(1);
        run_instr(4'd8, -1, 0, -1);
        chk("jump_ctrl", 32'(last_ctrl), 32'(12'b101_00_0000000));
        run_instr(4'd12, -1, 0, -1);
        chk("illegal_ctrl", 32'(last_ctrl), 32'(12'b100_00_0000000));
        run_instr(4'd9, -1, 10, -1);
        chk("halt_count", 32'(output_instrCount), 32'd2);

        reset_dut(1);
        run_instr(4'd3, 3, 0, -1);
`ifdef MEM_WAIT_EN
        chk("sw_wait_memwrite_cycles", 32'(tally_mw), 32'd4);
`else
        chk("sw_memwrite_cycles", 32'(tally_mw), 32'd1);
`endif
        chk("sw_pcwrite_cycles", 32'(tally_pcw), 32'd1);

        reset_dut(1);
        for (int i = 0; i < 300; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (op == 4'd9) op = 4'd1;
            run_instr(op, -1, 0, -1);
        end
        run_instr(4'd9, -1, 4, -1);

        reset_dut(1);
        for (int i = 0; i < 65535; i++) run_instr(4'd13, -1, 0, -1);
        chk("count_ffff", 32'(output_instrCount), 32'hFFFF);
        run_instr(4'd8, -1, 0, -1);
        chk("count_wrap", 32'(output_instrCount), 32'd0);

        run_instr(4'd1, -1, 0, 2);
        run_instr(4'd5, -1, 0, -1);
        chk("count_after_abort", 32'(output_instrCount), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
